// File: rtl/step_run_controller.sv
// Step/run controller: debounces the step button and gates the datapath clock enable
// for free run, single-cycle and single-instruction stepping with a PC breakpoint.
module step_run_controller #(
  parameter int unsigned DEBOUNCE_CYCLES  = 50000,
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned MAX_INSTR_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_btnStep,
  input  logic                  i_swInstrNCycle,
  input  logic                  i_swStepNRun,
  input  logic                  i_swEnableBreakpoint,
  input  logic [ADDR_WIDTH-1:0] i_breakpointAddress,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_instrDone,
  output logic                  o_clkEn,
  output logic                  o_breakHit,
  output logic                  o_stepTimeout,
  output logic [2:0]            o_state
);

  localparam int unsigned DB_CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CYC_CNT_W = $clog2(MAX_INSTR_CYCLES + 1);
  localparam logic [DB_CNT_W-1:0]  DB_LAST  = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CYC_CNT_W-1:0] CYC_LAST = CYC_CNT_W'(MAX_INSTR_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_PAUSE      = 3'd0,
    ST_RUN        = 3'd1,
    ST_STEP_CYCLE = 3'd2,
    ST_STEP_INSTR = 3'd3,
    ST_BREAK      = 3'd4
  } stateT;

  logic [1:0]           btnSync;
  logic [1:0]           instrSync;
  logic [1:0]           stepSync;
  logic [1:0]           bpEnSync;
  logic                 btnS;
  logic                 instrS;
  logic                 stepNRunS;
  logic                 bpEnS;

  logic [DB_CNT_W-1:0]  dbCnt;
  logic                 dbLevel;
  logic                 stepPulse;

  stateT                state;
  logic                 clkEn;
  logic                 breakHit;
  logic                 stepTimeout;
  logic                 bpSuppress;
  logic [CYC_CNT_W-1:0] cycCnt;
  logic                 done;
  logic                 hit;

  // Two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      btnSync   <= '0;
      instrSync <= '0;
      stepSync  <= '0;
      bpEnSync  <= '0;
    end else begin
      btnSync   <= {btnSync[0], i_btnStep};
      instrSync <= {instrSync[0], i_swInstrNCycle};
      stepSync  <= {stepSync[0], i_swStepNRun};
      bpEnSync  <= {bpEnSync[0], i_swEnableBreakpoint};
    end
  end

  assign btnS      = btnSync[1];
  assign instrS    = instrSync[1];
  assign stepNRunS = stepSync[1];
  assign bpEnS     = bpEnSync[1];

  // Level follows the button only after DEBOUNCE_CYCLES consecutive differing samples;
  // the pulse fires on the accepted press, never on release
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dbCnt     <= '0;
      dbLevel   <= 1'b0;
      stepPulse <= 1'b0;
    end else begin
      stepPulse <= 1'b0;
      if (btnS == dbLevel) begin
        dbCnt <= '0;
      end else if (dbCnt == DB_LAST) begin
        dbCnt     <= '0;
        dbLevel   <= btnS;
        stepPulse <= btnS;
      end else begin
        dbCnt <= dbCnt + DB_CNT_W'(1);
      end
    end
  end

  assign done = i_instrDone & clkEn;
  assign hit  = done & bpEnS & (i_pc == i_breakpointAddress) & ~bpSuppress;

  // Mode FSM; clkEn and breakHit are loaded with the decode of the state being entered
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_PAUSE;
      clkEn       <= 1'b0;
      breakHit    <= 1'b0;
      stepTimeout <= 1'b0;
      bpSuppress  <= 1'b0;
      cycCnt      <= '0;
    end else begin
      if (done) begin
        bpSuppress <= 1'b0;
      end
      case (state)
        ST_PAUSE: begin
          if (!stepNRunS) begin
            state <= ST_RUN;
            clkEn <= 1'b1;
          end else if (stepPulse) begin
            state  <= instrS ? ST_STEP_INSTR : ST_STEP_CYCLE;
            clkEn  <= 1'b1;
            cycCnt <= '0;
          end
        end
        ST_RUN: begin
          if (hit) begin
            state    <= ST_BREAK;
            clkEn    <= 1'b0;
            breakHit <= 1'b1;
          end else if (stepNRunS) begin
            state <= ST_PAUSE;
            clkEn <= 1'b0;
          end
        end
        ST_STEP_CYCLE: begin
          state <= ST_PAUSE;
          clkEn <= 1'b0;
        end
        ST_STEP_INSTR: begin
          if (done) begin
            state <= ST_PAUSE;
            clkEn <= 1'b0;
          end else if (cycCnt == CYC_LAST) begin
            state       <= ST_PAUSE;
            clkEn       <= 1'b0;
            stepTimeout <= 1'b1;
          end else begin
            cycCnt <= cycCnt + CYC_CNT_W'(1);
          end
        end
        ST_BREAK: begin
          // Suppression lets the resumed instruction at the breakpoint PC complete
          if (stepNRunS) begin
            state      <= ST_PAUSE;
            breakHit   <= 1'b0;
            bpSuppress <= 1'b1;
          end else if (stepPulse) begin
            state      <= ST_RUN;
            clkEn      <= 1'b1;
            breakHit   <= 1'b0;
            bpSuppress <= 1'b1;
          end
        end
        default: begin
          state    <= ST_PAUSE;
          clkEn    <= 1'b0;
          breakHit <= 1'b0;
        end
      endcase
    end
  end

  assign o_clkEn       = clkEn;
  assign o_breakHit    = breakHit;
  assign o_stepTimeout = stepTimeout;
  assign o_state       = state;

endmodule
